// File: rtl/avalon_arbiter_2to1.sv
// Two-master, one-slave Avalon-MM arbiter placed in front of a single-port RAM.
// Master 0 is the instruction bus and master 1 is the data bus.
// Grants are registered and round-robin. A grant is held until its transfer
// completes, and one IDLE bubble follows before the next arbitration.
//
// Handshake: a transfer completes in any cycle where the granted master's
// s_read or s_write is high and s_waitrequest is low. A master sees
// waitrequest = 1 until that cycle, and it must hold its request stable
// while stalled. s_readdata is valid only in the completion cycle.
module avalon_arbiter_2to1 #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    // master 0 (ibus)
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byte_enable,
    input  logic [DW-1:0]     m0_writedata,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_waitrequest,
    // master 1 (dbus)
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byte_enable,
    input  logic [DW-1:0]     m1_writedata,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_waitrequest,
    // slave
    output logic              s_read,
    output logic              s_write,
    output logic [AW-1:0]     s_address,
    output logic [DW/8-1:0]   s_byte_enable,
    output logic [DW-1:0]     s_writedata,
    input  logic [DW-1:0]     s_readdata,
    input  logic              s_waitrequest,
    // debug: current arbiter state (0 = IDLE, 1 = GNT0, 2 = GNT1)
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;   // 0: m0 was granted last

    logic req0, req1;
    logic done;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Completion of the transfer currently on the slave port. In IDLE the
    // slave strobes are 0, so this only fires in a grant state.
    assign done = (s_read | s_write) & ~s_waitrequest;

    // State and round-robin pointer registers. Reset leaves the pointer at m1
    // so that m0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic: arbitrate in IDLE and release the grant on completion
    // or when the granted master withdraws its request.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_grant_q)) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0: begin
                if (!req0 || done) state_d = IDLE;
            end
            GNT1: begin
                if (!req1 || done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: route the granted master to the slave and stall the
    // other master. Only the granted master sees the slave's waitrequest.
    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_byte_enable  = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        unique case (state_q)
            GNT0: begin
                s_read         = m0_read;
                s_write        = m0_write;
                s_address      = m0_address;
                s_byte_enable  = m0_byte_enable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest;
            end
            GNT1: begin
                s_read         = m1_read;
                s_write        = m1_write;
                s_address      = m1_address;
                s_byte_enable  = m1_byte_enable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; it is meaningful only in the completion cycle of
    // the granted master.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_avalon_arbiter_2to1.sv
// Directed, table-driven bench for avalon_arbiter_2to1 with a small RAM slave
// model whose stall is controlled by the bench.
module tb_avalon_arbiter_2to1;

  localparam int AW = 18;
  localparam int DW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [AW-1:0] A0  = 18'h00020;
  localparam logic [AW-1:0] A1  = 18'h00010;
  localparam logic [3:0]    BE0 = 4'h3;
  localparam logic [3:0]    BE1 = 4'hF;
  localparam logic [31:0]   WD0 = 32'h11111111;
  localparam logic [31:0]   WD1 = 32'hDEADBEEF;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [3:0]    m0_byte_enable, m1_byte_enable;
  logic [31:0]   m0_writedata, m1_writedata;
  logic [31:0]   m0_readdata, m1_readdata;
  logic          m0_waitrequest, m1_waitrequest;
  logic          s_read, s_write;
  logic [AW-1:0] s_address;
  logic [3:0]    s_byte_enable;
  logic [31:0]   s_writedata;
  logic [31:0]   s_readdata;
  logic          s_waitrequest;
  logic [1:0]    dbg_state;

  avalon_arbiter_2to1 #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .m0_read(m0_read),
    .m0_write(m0_write),
    .m0_address(m0_address),
    .m0_byte_enable(m0_byte_enable),
    .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_read(m1_read),
    .m1_write(m1_write),
    .m1_address(m1_address),
    .m1_byte_enable(m1_byte_enable),
    .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .s_read(s_read),
    .s_write(s_write),
    .s_address(s_address),
    .s_byte_enable(s_byte_enable),
    .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest),
    .dbg_state(dbg_state)
  );

  // slave RAM model: combinational read, write on completion
  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A50000 | i;
  end
  assign s_readdata = mem[s_address[5:0]];
  always @(posedge clk) begin
    if (s_write && !s_waitrequest) mem[s_address[5:0]] <= s_writedata;
  end

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // vector table
  typedef struct {
    logic        m0_rd, m0_wr, m1_rd, m1_wr, swait;
    logic [1:0]  st;
    logic        s_rd, s_wr, w0, w1;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic m0r, input logic m0w, input logic m1r, input logic m1w,
                     input logic sw, input logic [1:0] st, input logic srd, input logic swr,
                     input logic w0, input logic w1, input logic chk, input logic [31:0] rd);
    vec_t v;
    v.m0_rd = m0r; v.m0_wr = m0w; v.m1_rd = m1r; v.m1_wr = m1w; v.swait = sw;
    v.st = st; v.s_rd = srd; v.s_wr = swr; v.w0 = w0; v.w1 = w1;
    v.chk_rd = chk; v.rdata = rd;
    vq.push_back(v);
  endtask

  task automatic drive(input logic m0r, input logic m0w, input logic m1r, input logic m1w,
                       input logic sw);
    m0_read = m0r; m0_write = m0w; m1_read = m1r; m1_write = m1w; s_waitrequest = sw;
  endtask

  task automatic check_row(input int i, input vec_t v);
    logic [AW-1:0] ea;
    logic [3:0]    eb;
    logic [31:0]   ew;
    ea = (v.st == ST_GNT0) ? A0  : (v.st == ST_GNT1) ? A1  : '0;
    eb = (v.st == ST_GNT0) ? BE0 : (v.st == ST_GNT1) ? BE1 : '0;
    ew = (v.st == ST_GNT0) ? WD0 : (v.st == ST_GNT1) ? WD1 : '0;
    check($sformatf("row%0d state", i), 32'(dbg_state), 32'(v.st));
    check($sformatf("row%0d s_read", i), 32'(s_read), 32'(v.s_rd));
    check($sformatf("row%0d s_write", i), 32'(s_write), 32'(v.s_wr));
    check($sformatf("row%0d s_address", i), 32'(s_address), 32'(ea));
    check($sformatf("row%0d s_byte_enable", i), 32'(s_byte_enable), 32'(eb));
    check($sformatf("row%0d s_writedata", i), s_writedata, ew);
    check($sformatf("row%0d m0_waitrequest", i), 32'(m0_waitrequest), 32'(v.w0));
    check($sformatf("row%0d m1_waitrequest", i), 32'(m1_waitrequest), 32'(v.w1));
    if (v.chk_rd) begin
      check($sformatf("row%0d m0_readdata", i), m0_readdata, v.rdata);
      check($sformatf("row%0d m1_readdata", i), m1_readdata, v.rdata);
    end
  endtask

  initial begin
    //   m0r m0w m1r m1w sw  state    srd swr w0 w1 chk rdata
    // contention: strict alternation starting with m0
    add(1, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 0
    add(1, 0, 1, 0, 0, ST_GNT0, 1, 0, 0, 1, 1, 32'hA5A50020);   // 1
    add(1, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 2
    add(1, 0, 1, 0, 0, ST_GNT1, 1, 0, 1, 0, 1, 32'hA5A50010);   // 3
    add(1, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 4
    add(1, 0, 1, 0, 0, ST_GNT0, 1, 0, 0, 1, 1, 32'hA5A50020);   // 5
    add(1, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 6
    // slave stall of 3 cycles in GNT1, completion on the 4th
    add(1, 0, 1, 0, 1, ST_GNT1, 1, 0, 1, 1, 0, 32'h0);          // 7
    add(1, 0, 1, 0, 1, ST_GNT1, 1, 0, 1, 1, 0, 32'h0);          // 8
    add(1, 0, 1, 0, 1, ST_GNT1, 1, 0, 1, 1, 0, 32'h0);          // 9
    add(1, 0, 1, 0, 0, ST_GNT1, 1, 0, 1, 0, 1, 32'hA5A50010);   // 10
    // single master: m1 writes DEADBEEF to 0x10, then reads it back
    add(0, 0, 0, 1, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 11
    add(0, 0, 0, 1, 0, ST_GNT1, 0, 1, 1, 0, 0, 32'h0);          // 12
    add(0, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 13
    add(0, 0, 1, 0, 0, ST_GNT1, 1, 0, 1, 0, 1, 32'hDEADBEEF);   // 14
    add(0, 0, 0, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 15
    // violation: m0 write stalls, then m0 withdraws; m1 is granted next
    add(0, 1, 0, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 16
    add(0, 1, 0, 0, 1, ST_GNT0, 0, 1, 1, 1, 0, 32'h0);          // 17
    add(0, 0, 1, 0, 1, ST_GNT0, 0, 0, 1, 1, 0, 32'h0);          // 18
    add(0, 0, 1, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 19
    add(0, 0, 1, 0, 0, ST_GNT1, 1, 0, 1, 0, 1, 32'hDEADBEEF);   // 20
    // aborted m0 write left memory untouched
    add(1, 0, 0, 0, 0, ST_IDLE, 0, 0, 1, 1, 0, 32'h0);          // 21
    add(1, 0, 0, 0, 0, ST_GNT0, 1, 0, 0, 1, 1, 32'hA5A50020);   // 22

    m0_address = A0; m0_byte_enable = BE0; m0_writedata = WD0;
    m1_address = A1; m1_byte_enable = BE1; m1_writedata = WD1;

    // reset held with both masters requesting
    rst = 1'b0;
    drive(1, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset s_read", 32'(s_read), 32'h0);
    check("reset s_write", 32'(s_write), 32'h0);
    check("reset m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    check("reset m1_waitrequest", 32'(m1_waitrequest), 32'h1);
    rst = 1'b1;

    // table: inputs applied at the falling edge, outputs checked 1 ns later
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].m0_rd, vq[i].m0_wr, vq[i].m1_rd, vq[i].m1_wr, vq[i].swait);
      #1;
      check_row(i, vq[i]);
      @(negedge clk);
    end

    // mid-transfer reset in the second stall cycle of a GNT0 read
    drive(1, 0, 0, 0, 1);
    #1;
    check("mrst idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    #1;
    check("mrst stall1 state", 32'(dbg_state), 32'(ST_GNT0));
    check("mrst stall1 m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    @(negedge clk);
    #1;
    check("mrst stall2 s_read", 32'(s_read), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("mrst async s_read", 32'(s_read), 32'h0);
    check("mrst async state", 32'(dbg_state), 32'(ST_IDLE));
    check("mrst async m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 0, 0);
    #1;
    check("mrst post idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    #1;
    check("mrst post state", 32'(dbg_state), 32'(ST_GNT1));
    check("mrst post s_read", 32'(s_read), 32'h1);
    check("mrst post s_address", 32'(s_address), 32'(A1));
    check("mrst post m1_waitrequest", 32'(m1_waitrequest), 32'h0);
    check("mrst post m1_readdata", m1_readdata, 32'hDEADBEEF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
